onchip_mem_block_reader: RTL and testbench

//   Avalon-MM read master that fetches a block of 32-bit words from an on-chip memory slave and

---
 rtl/onchip_mem_block_reader_if.sv | 26 ++
 rtl/onchip_mem_block_reader.sv | 158 +++++++++++++++
 tb/tb_onchip_mem_block_reader.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/onchip_mem_block_reader_if.sv
// Bus bundle for the block reader: Avalon-MM read master side plus the
// valid/ready stream source. The reader uses the master modport; the memory
// slave and the stream consumer together form the slave side.
interface onchip_mem_block_reader_if #(
  parameter int ADDR_W = 13
);
  logic [ADDR_W-1:0] avm_address;
  logic              avm_read;
  logic [3:0]        avm_byteenable;
  logic              avm_waitrequest;
  logic [31:0]       avm_readdata;
  logic              avm_readdatavalid;
  logic [31:0]       src_data;
  logic              src_valid;
  logic              src_ready;

  modport master (
    output avm_address, avm_read, avm_byteenable, src_data, src_valid,
    input  avm_waitrequest, avm_readdata, avm_readdatavalid, src_ready
  );

  modport slave (
    input  avm_address, avm_read, avm_byteenable, src_data, src_valid,
    output avm_waitrequest, avm_readdata, avm_readdatavalid, src_ready
  );
endinterface

// File: rtl/onchip_mem_block_reader.sv
// Block reader: pipelined Avalon-MM reads of word_count words from base_addr,
// streamed out through a small FIFO. Reads are only issued while
// inflight + fifo_count < FIFO_DEPTH, so returned data always has a slot.
// Optional feature macro: MEM_READER_CHECKSUM_EN (running sum of pushed words).
module onchip_mem_block_reader #(
  parameter int ADDR_W     = 13,
  parameter int CNT_W      = 14,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [CNT_W-1:0]  word_count_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [31:0]       checksum_o,
  onchip_mem_block_reader_if.master bus
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CRD_W = PTR_W + 1;
  localparam logic [CRD_W:0] OCC_MAX = (CRD_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  remain_q, remain_d;
  logic [CRD_W-1:0]  inflight_q, inflight_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [31:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CRD_W-1:0]  fifo_cnt_q;

  logic [CRD_W:0]    occ;
  logic              credit_ok, rd_req, accept, rvalid, pop;

  // Credit check and handshake qualifiers
  always_comb begin
    occ       = {1'b0, inflight_q} + {1'b0, fifo_cnt_q};
    credit_ok = occ < OCC_MAX;
    rd_req    = (state_q == S_ISSUE) && credit_ok;
    accept    = rd_req && !bus.avm_waitrequest;
    // Returns arriving while idle are strays from an aborted transfer
    rvalid    = bus.avm_readdatavalid && (state_q != S_IDLE);
    pop       = (fifo_cnt_q != '0) && bus.src_ready;
  end

  // Next-state logic for the transfer FSM and its counters
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          addr_d   = base_addr_i;
          remain_d = word_count_i;
          if (word_count_i == '0) begin
            done_d = 1'b1;
          end else begin
            busy_d  = 1'b1;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (accept) begin
          addr_d   = addr_q + 1'b1;
          remain_d = remain_q - 1'b1;
          if (remain_q == CNT_W'(1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (inflight_q == '0 && fifo_cnt_q == '0) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outstanding read tracking; accept and return in one cycle cancel out
  always_comb begin
    inflight_d = inflight_q;
    if (accept && !rvalid)      inflight_d = inflight_q + 1'b1;
    else if (!accept && rvalid) inflight_d = inflight_q - 1'b1;
  end

  // Control state registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      remain_q   <= '0;
      inflight_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      remain_q   <= remain_d;
      inflight_q <= inflight_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (rvalid) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)    rd_ptr_q <= rd_ptr_q + 1'b1;
      if (rvalid && !pop)      fifo_cnt_q <= fifo_cnt_q + 1'b1;
      else if (!rvalid && pop) fifo_cnt_q <= fifo_cnt_q - 1'b1;
    end
  end

  // FIFO storage; contents are qualified by the count, so no reset needed
  always_ff @(posedge clk_i) begin
    if (rvalid) fifo_mem[wr_ptr_q] <= bus.avm_readdata;
  end

`ifdef MEM_READER_CHECKSUM_EN
  logic [31:0] sum_q;

  // Running sum of pushed words, restarted by each accepted start
  always_ff @(posedge clk_i) begin
    if (reset_i)                          sum_q <= '0;
    else if (state_q == S_IDLE && start_i) sum_q <= '0;
    else if (rvalid)                      sum_q <= sum_q + bus.avm_readdata;
  end

  assign checksum_o = sum_q;
`else
  assign checksum_o = 32'h0;
`endif

  assign busy_o             = busy_q;
  assign done_o             = done_q;
  assign bus.avm_address    = addr_q;
  assign bus.avm_read       = rd_req;
  assign bus.avm_byteenable = 4'hF;
  assign bus.src_data       = fifo_mem[rd_ptr_q];
  assign bus.src_valid      = (fifo_cnt_q != '0);

endmodule

// File: tb/tb_onchip_mem_block_reader.sv
// Bench for onchip_mem_block_reader: memory slave model with optional random
// waitrequest / return latency, scoreboard of expected stream words and
// addresses, and a negedge monitor that checks each delivered word.
module tb_onchip_mem_block_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [12:0] base_addr;
  logic [13:0] word_count;
  logic        busy, done;
  logic [31:0] checksum;

  always #5 clk = ~clk;

  onchip_mem_block_reader_if #(.ADDR_W(13)) bus ();

  onchip_mem_block_reader #(.ADDR_W(13), .CNT_W(14), .FIFO_DEPTH(8)) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .start_i      (start),
    .base_addr_i  (base_addr),
    .word_count_i (word_count),
    .busy_o       (busy),
    .done_o       (done),
    .checksum_o   (checksum),
    .bus          (bus.master)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] csum(input logic [31:0] v);
`ifdef MEM_READER_CHECKSUM_EN
    return v;
`else
    return 32'h0 & v;
`endif
  endfunction

  // Scoreboard queues and counters shared with the monitors
  logic [31:0] exp_q[$];
  logic [12:0] exp_addr[$];
  int          done_cnt = 0;
  int          acc_cnt  = 0;
  logic        wr_rand  = 1'b0;
  logic        lat_rand = 1'b0;

  typedef struct packed {
    int          due;
    logic [31:0] d;
  } rsp_t;
  rsp_t pend[$];

  // Memory slave: mem[a] = a + 1, in-order returns, optional stalls
  initial begin : slave
    int          cyc;
    int          last_due;
    logic        acc, stall, rst;
    logic [12:0] aaddr;
    int          lat, due;
    rsp_t        r;
    cyc = 0;
    last_due = 0;
    bus.avm_waitrequest   = 1'b0;
    bus.avm_readdatavalid = 1'b0;
    bus.avm_readdata      = 32'h0;
    forever begin
      @(posedge clk);
      cyc++;
      acc   = bus.avm_read && !bus.avm_waitrequest;
      stall = bus.avm_read && bus.avm_waitrequest;
      aaddr = bus.avm_address;
      rst   = reset;
      #1;
      if (rst) begin
        pend.delete();
        last_due = cyc;
        bus.avm_readdatavalid = 1'b0;
        bus.avm_waitrequest   = 1'b0;
        continue;
      end
      if (stall) begin
        chk("addr_hold", {19'd0, bus.avm_address}, {19'd0, aaddr});
        chk("read_hold", {31'd0, bus.avm_read}, 32'd1);
      end
      if (acc) begin
        acc_cnt++;
        if (exp_addr.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_read: got address %h, expected no read", aaddr);
        end else begin
          chk("avm_address", {19'd0, aaddr}, {19'd0, exp_addr.pop_front()});
        end
        lat = lat_rand ? int'($urandom_range(1, 3)) : 1;
        due = cyc + lat;
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        r.due = due;
        r.d   = {19'd0, aaddr} + 32'd1;
        pend.push_back(r);
      end
      if (pend.size() != 0 && pend[0].due == cyc + 1) begin
        r = pend.pop_front();
        bus.avm_readdatavalid = 1'b1;
        bus.avm_readdata      = r.d;
      end else begin
        bus.avm_readdatavalid = 1'b0;
        bus.avm_readdata      = $urandom;
      end
      bus.avm_waitrequest = wr_rand ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  // Stream monitor: pop expected word on every transfer, check hold stability
  logic        prev_hold = 1'b0;
  logic [31:0] prev_data = 32'h0;
  always @(negedge clk) begin
    if (reset) begin
      prev_hold <= 1'b0;
    end else begin
      if (done) done_cnt++;
      if (prev_hold && bus.src_valid)
        chk("src_hold", bus.src_data, prev_data);
      if (bus.src_valid && bus.src_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_word: got %h, expected no word", bus.src_data);
        end else begin
          chk("src_data", bus.src_data, exp_q.pop_front());
        end
      end
      prev_hold <= bus.src_valid && !bus.src_ready;
      prev_data <= bus.src_data;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [12:0] b, input logic [13:0] c);
    start = 1'b1; base_addr = b; word_count = c;
    tick(1);
    start = 1'b0;
  endtask

  task automatic expect_words(input logic [12:0] b, input int c);
    logic [12:0] a;
    for (int i = 0; i < c; i++) begin
      a = b + 13'(i);
      exp_addr.push_back(a);
      exp_q.push_back({19'd0, a} + 32'd1);
    end
  endtask

  task automatic wait_done(input string nm, input int d0);
    int t;
    t = 0;
    while (done_cnt == d0 && t < 3000) begin
      tick(1);
      t++;
    end
    chk(nm, done_cnt - d0, 1);
  endtask

  initial begin : main
    int d0, a0;
    reset = 1'b1; start = 1'b0; base_addr = '0; word_count = '0;
    bus.src_ready = 1'b1;
    tick(3);
    chk("rst_busy",   {31'd0, busy}, 0);
    chk("rst_done",   {31'd0, done}, 0);
    chk("rst_read",   {31'd0, bus.avm_read}, 0);
    chk("rst_valid",  {31'd0, bus.src_valid}, 0);
    chk("rst_addr",   {19'd0, bus.avm_address}, 0);
    chk("rst_cksum",  checksum, 0);
    chk("byteenable", {28'd0, bus.avm_byteenable}, 32'hF);
    reset = 1'b0;
    tick(2);

    // T1: 4 words from 0, plus a start while busy that must be ignored
    d0 = done_cnt;
    expect_words(13'h0000, 4);
    do_start(13'h0000, 14'd4);
    chk("t1_busy", {31'd0, busy}, 1);
    tick(1);
    do_start(13'h0500, 14'd3);
    wait_done("t1_done", d0);
    chk("t1_cksum", checksum, csum(32'h0000000A));
    tick(4);
    chk("t1_done_once", done_cnt - d0, 1);
    chk("t1_idle", {31'd0, busy}, 0);

    // T3: address wrap at the top of the word space
    d0 = done_cnt;
    exp_addr.push_back(13'h1FFE); exp_addr.push_back(13'h1FFF);
    exp_addr.push_back(13'h0000); exp_addr.push_back(13'h0001);
    exp_q.push_back(32'h1FFF); exp_q.push_back(32'h2000);
    exp_q.push_back(32'h0001); exp_q.push_back(32'h0002);
    do_start(13'h1FFE, 14'd4);
    wait_done("t3_done", d0);
    chk("t3_cksum", checksum, csum(32'h00004002));
    tick(2);

    // T2: consumer stalled, credit limit caps reads at FIFO depth
    d0 = done_cnt;
    a0 = acc_cnt;
    bus.src_ready = 1'b0;
    expect_words(13'h0100, 16);
    do_start(13'h0100, 14'd16);
    tick(40);
    chk("t2_reads", acc_cnt - a0, 8);
    chk("t2_read_low", {31'd0, bus.avm_read}, 0);
    chk("t2_valid", {31'd0, bus.src_valid}, 1);
    chk("t2_head", bus.src_data, 32'h0101);
    bus.src_ready = 1'b1;
    wait_done("t2_done", d0);
    chk("t2_total", acc_cnt - a0, 16);
    chk("t2_cksum", checksum, csum(32'h00001088));
    tick(2);

    // T4: random waitrequest and return latency
    d0 = done_cnt;
    wr_rand = 1'b1; lat_rand = 1'b1;
    expect_words(13'h0040, 12);
    do_start(13'h0040, 14'd12);
    wait_done("t4_done", d0);
    chk("t4_cksum", checksum, csum(32'h0000034E));
    wr_rand = 1'b0; lat_rand = 1'b0;
    tick(3);

    // T5: empty transfer
    d0 = done_cnt;
    a0 = acc_cnt;
    do_start(13'h0700, 14'd0);
    chk("t5_done_pulse", {31'd0, done}, 1);
    chk("t5_no_read", {31'd0, bus.avm_read}, 0);
    tick(1);
    chk("t5_done_clear", {31'd0, done}, 0);
    tick(2);
    chk("t5_reads", acc_cnt - a0, 0);
    chk("t5_done_once", done_cnt - d0, 1);

    // T6: reset mid-issue, then a fresh transfer
    bus.src_ready = 1'b0;
    expect_words(13'h0200, 16);
    do_start(13'h0200, 14'd16);
    tick(3);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("t6_busy",  {31'd0, busy}, 0);
    chk("t6_done",  {31'd0, done}, 0);
    chk("t6_read",  {31'd0, bus.avm_read}, 0);
    chk("t6_valid", {31'd0, bus.src_valid}, 0);
    chk("t6_addr",  {19'd0, bus.avm_address}, 0);
    chk("t6_cksum", checksum, 0);
    exp_addr.delete();
    exp_q.delete();
    bus.src_ready = 1'b1;
    tick(2);
    d0 = done_cnt;
    expect_words(13'h0010, 4);
    do_start(13'h0010, 14'd4);
    wait_done("t6_done2", d0);
    chk("t6_cksum2", checksum, csum(32'h0000004A));

    tick(5);
    chk("drained_words", exp_q.size(), 0);
    chk("drained_addrs", exp_addr.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
